// File: rtl/mem_port_arbiter.sv
// Arbitrates NUM_CH word requesters onto one byte-wide RAM port, splitting each
// 1..4-byte request into a little-endian byte sequence with configurable read latency.
module mem_port_arbiter #(
    parameter int NUM_CH   = 2,
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int RD_LAT   = 1,
    parameter int ARB_MODE = 0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     rdy,
    input  logic [NUM_CH-1:0]        req_i,
    input  logic [NUM_CH-1:0]        we_i,
    input  logic [3*NUM_CH-1:0]      len_i,
    input  logic [ADDR_W*NUM_CH-1:0] addr_i,
    input  logic [DATA_W*NUM_CH-1:0] wdata_i,
    input  logic [NUM_CH-1:0]        flush_i,
    output logic [NUM_CH-1:0]        ack_o,
    output logic [DATA_W-1:0]        rdata_o,
    output logic [NUM_CH-1:0]        grant_o,
    output logic                     busy_o,
    input  logic [7:0]               din,
    output logic [7:0]               dout,
    output logic [ADDR_W-1:0]        addr_o,
    output logic                     wr_o
);
    localparam int unsigned NB      = DATA_W / 8;
    localparam int unsigned NCH     = NUM_CH;
    localparam int unsigned CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int unsigned BI_W    = (NB > 1) ? $clog2(NB) : 1;
    localparam logic [2:0]  NB3     = 3'(NB);
    localparam logic [3:0]  LAT4    = 4'(RD_LAT);
    localparam logic [CH_W-1:0] RR_INIT = CH_W'(NUM_CH - 1);

    typedef enum logic [1:0] {IDLE, XFER, DONE} state_t;

    state_t            state_q, state_d;
    logic [CH_W-1:0]   ch_q, ch_d;
    logic [CH_W-1:0]   rr_q, rr_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [2:0]        len_q, len_d;
    logic              we_q, we_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [7:0]        rbuf_q [NB];
    logic [7:0]        rbuf_d [NB];
    logic [DATA_W-1:0] rdata_q, rdata_d;

    logic [2:0]        len_a   [NUM_CH];
    logic [ADDR_W-1:0] addr_a  [NUM_CH];
    logic [DATA_W-1:0] wdata_a [NUM_CH];
    logic [7:0]        wbyte_a [NB];
    logic [7:0]        cap_buf [NB];
    logic [DATA_W-1:0] cap_flat;

    logic [NUM_CH-1:0] elig;
    logic [CH_W-1:0]   win;
    logic              found;
    int unsigned       idx;
    logic [2:0]        len_sel, len_eff;
    logic [3:0]        acnt, last_cnt;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_chan
        assign len_a[g]   = len_i[g*3 +: 3];
        assign addr_a[g]  = addr_i[g*ADDR_W +: ADDR_W];
        assign wdata_a[g] = wdata_i[g*DATA_W +: DATA_W];
    end

    for (genvar g = 0; g < NB; g++) begin : g_byte
        assign wbyte_a[g]       = wdata_q[g*8 +: 8];
        assign cap_flat[g*8 +: 8] = cap_buf[g];
    end

    // Fixed mode keeps the last (highest) eligible index; RR takes the first after the pointer.
    always_comb begin
        elig  = req_i & ~flush_i;
        win   = '0;
        found = 1'b0;
        idx   = 0;
        if (ARB_MODE == 0) begin
            for (int unsigned i = 0; i < NCH; i++) begin
                if (elig[CH_W'(i)]) win = CH_W'(i);
            end
        end else begin
            for (int unsigned k = 1; k <= NCH; k++) begin
                idx = (32'(rr_q) + k) % NCH;
                if (!found && elig[CH_W'(idx)]) begin
                    win   = CH_W'(idx);
                    found = 1'b1;
                end
            end
        end
        len_sel = len_a[win];
        if (len_sel == 3'd0)     len_eff = 3'd1;
        else if (len_sel > NB3)  len_eff = NB3;
        else                     len_eff = len_sel;
    end

    always_comb begin
        state_d = state_q;
        ch_d    = ch_q;
        rr_d    = rr_q;
        base_d  = base_q;
        len_d   = len_q;
        we_d    = we_q;
        wdata_d = wdata_q;
        cnt_d   = cnt_q;
        rbuf_d  = rbuf_q;
        rdata_d = rdata_q;
        ack_o   = '0;
        addr_o  = '0;
        dout    = 8'h00;
        wr_o    = 1'b0;

        // Address sticks at the last byte once the read issue phase is over.
        acnt     = (cnt_q < {1'b0, len_q}) ? cnt_q : ({1'b0, len_q} - 4'd1);
        last_cnt = we_q ? ({1'b0, len_q} - 4'd1) : ({1'b0, len_q} + LAT4 - 4'd1);
        cap_buf  = rbuf_q;
        if (!we_q && cnt_q >= LAT4) cap_buf[BI_W'(cnt_q - LAT4)] = din;

        busy_o  = (state_q != IDLE);
        grant_o = busy_o ? (NUM_CH'(1) << ch_q) : '0;

        case (state_q)
            IDLE: begin
                if (rdy && |elig) begin
                    state_d = XFER;
                    ch_d    = win;
                    base_d  = addr_a[win];
                    len_d   = len_eff;
                    we_d    = we_i[win];
                    wdata_d = wdata_a[win];
                    cnt_d   = '0;
                    rbuf_d  = '{default: '0};
                    if (ARB_MODE == 1) rr_d = win;
                end
            end
            XFER: begin
                addr_o = base_q + ADDR_W'(acnt);
                dout   = we_q ? wbyte_a[BI_W'(acnt)] : 8'h00;
                wr_o   = we_q & rdy;
                if (!we_q && flush_i[ch_q]) begin
                    state_d = IDLE;
                end else if (rdy) begin
                    rbuf_d = cap_buf;
                    if (cnt_q == last_cnt) begin
                        state_d = DONE;
                        if (!we_q) rdata_d = cap_flat;
                    end else begin
                        cnt_d = cnt_q + 4'd1;
                    end
                end
            end
            DONE: begin
                if (rdy) begin
                    ack_o[ch_q] = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            ch_q    <= '0;
            rr_q    <= RR_INIT;
            base_q  <= '0;
            len_q   <= 3'd1;
            we_q    <= 1'b0;
            wdata_q <= '0;
            cnt_q   <= '0;
            rbuf_q  <= '{default: '0};
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            ch_q    <= ch_d;
            rr_q    <= rr_d;
            base_q  <= base_d;
            len_q   <= len_d;
            we_q    <= we_d;
            wdata_q <= wdata_d;
            cnt_q   <= cnt_d;
            rbuf_q  <= rbuf_d;
            rdata_q <= rdata_d;
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench: fixed-priority/RD_LAT=1 and round-robin/RD_LAT=2 instances, each with a RAM model.
module tb_mem_port_arbiter;
    logic        clk = 1'b0;
    logic        rst, rdy;

    logic [1:0]  a_req, a_we, a_flush, a_ack, a_grant;
    logic [5:0]  a_len;
    logic [63:0] a_addr_i, a_wdata;
    logic [31:0] a_rdata, a_addr;
    logic        a_busy, a_wr;
    logic [7:0]  a_din, a_dout;

    logic [1:0]  b_req, b_we, b_flush, b_ack, b_grant;
    logic [5:0]  b_len;
    logic [63:0] b_addr_i, b_wdata;
    logic [31:0] b_rdata, b_addr;
    logic        b_busy, b_wr;
    logic [7:0]  b_din, b_dout;

    int nchk = 0;
    int nerr = 0;
    logic [1:0] eg;

    always #5 clk = ~clk;

    mem_port_arbiter #(.NUM_CH(2), .ADDR_W(32), .DATA_W(32), .RD_LAT(1), .ARB_MODE(0)) u_a (
        .clk(clk), .rst(rst), .rdy(rdy), .req_i(a_req), .we_i(a_we), .len_i(a_len),
        .addr_i(a_addr_i), .wdata_i(a_wdata), .flush_i(a_flush), .ack_o(a_ack),
        .rdata_o(a_rdata), .grant_o(a_grant), .busy_o(a_busy), .din(a_din),
        .dout(a_dout), .addr_o(a_addr), .wr_o(a_wr));

    mem_port_arbiter #(.NUM_CH(2), .ADDR_W(32), .DATA_W(32), .RD_LAT(2), .ARB_MODE(1)) u_b (
        .clk(clk), .rst(rst), .rdy(rdy), .req_i(b_req), .we_i(b_we), .len_i(b_len),
        .addr_i(b_addr_i), .wdata_i(b_wdata), .flush_i(b_flush), .ack_o(b_ack),
        .rdata_o(b_rdata), .grant_o(b_grant), .busy_o(b_busy), .din(b_din),
        .dout(b_dout), .addr_o(b_addr), .wr_o(b_wr));

    // RAM models: synchronous write, read data RD_LAT active cycles after the address, paused by rdy.
    logic [7:0]  mem_a [1024];
    logic [7:0]  mem_b [1024];
    logic [31:0] pa1, pb1, pb2;

    always @(posedge clk) begin
        if (rst) begin
            mem_a <= '{default: 8'h00};
            mem_a[10'h100] <= 8'h11;
            mem_a[10'h101] <= 8'h22;
            mem_a[10'h102] <= 8'h33;
            mem_a[10'h103] <= 8'h44;
            mem_a[10'h022] <= 8'h5A;
            mem_a[10'h023] <= 8'hA5;
            pa1 <= '0;
        end else begin
            if (a_wr) mem_a[a_addr[9:0]] <= a_dout;
            if (rdy) pa1 <= a_addr;
        end
    end
    assign a_din = mem_a[pa1[9:0]];

    always @(posedge clk) begin
        if (rst) begin
            mem_b <= '{default: 8'h00};
            mem_b[10'h010] <= 8'hA0;
            mem_b[10'h011] <= 8'hB1;
            mem_b[10'h3FF] <= 8'h7E;
            mem_b[10'h000] <= 8'h5C;
            pb1 <= '0;
            pb2 <= '0;
        end else begin
            if (b_wr) mem_b[b_addr[9:0]] <= b_dout;
            if (rdy) begin
                pb1 <= b_addr;
                pb2 <= pb1;
            end
        end
    end
    assign b_din = mem_b[pb2[9:0]];

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1; rdy = 1'b1;
        a_req = '0; a_we = '0; a_len = '0; a_addr_i = '0; a_wdata = '0; a_flush = '0;
        b_req = '0; b_we = '0; b_len = '0; b_addr_i = '0; b_wdata = '0; b_flush = '0;
        tick; tick; tick;
        chk("rst_ack",   64'(a_ack),   64'(0));
        chk("rst_rdata", 64'(a_rdata), 64'(0));
        chk("rst_grant", 64'(a_grant), 64'(0));
        chk("rst_busy",  64'(a_busy),  64'(0));
        chk("rst_addr",  64'(a_addr),  64'(0));
        chk("rst_dout",  64'(a_dout),  64'(0));
        chk("rst_wr",    64'(a_wr),    64'(0));
        chk("rst_b_busy", 64'(b_busy), 64'(0));
        rst = 1'b0;

        // ch0 read len=4 at 0x100
        a_req = 2'b01; a_len[2:0] = 3'd4; a_addr_i[31:0] = 32'h100;
        for (int i = 0; i < 4; i++) begin
            tick;
            chk("rd4_addr",  64'(a_addr),  64'(32'h100 + i));
            chk("rd4_grant", 64'(a_grant), 64'(2'b01));
            chk("rd4_wr",    64'(a_wr),    64'(0));
        end
        tick;
        chk("rd4_addr_hold", 64'(a_addr), 64'(32'h103));
        chk("rd4_no_ack",    64'(a_ack),  64'(0));
        tick;
        chk("rd4_ack",   64'(a_ack),   64'(2'b01));
        chk("rd4_rdata", 64'(a_rdata), 64'(32'h44332211));
        chk("rd4_busy",  64'(a_busy),  64'(1));
        a_req = 2'b00;
        tick;
        chk("rd4_idle", 64'(a_busy), 64'(0));
        chk("rd4_addr0", 64'(a_addr), 64'(0));

        // len=0 read acts as one byte, upper bytes zero-extended
        a_req = 2'b01; a_len[2:0] = 3'd0; a_addr_i[31:0] = 32'h100;
        tick; tick;
        chk("len0_no_ack", 64'(a_ack), 64'(0));
        tick;
        chk("len0_ack",   64'(a_ack),   64'(2'b01));
        chk("len0_rdata", 64'(a_rdata), 64'(32'h00000011));
        a_req = 2'b00;
        tick;

        // ch1 write len=2 at 0x20
        a_req = 2'b10; a_we = 2'b10; a_len[5:3] = 3'd2; a_addr_i[63:32] = 32'h20;
        a_wdata[63:32] = 32'hAABBCCDD;
        tick;
        chk("wr_wr1",    64'(a_wr),    64'(1));
        chk("wr_addr1",  64'(a_addr),  64'(32'h20));
        chk("wr_dout1",  64'(a_dout),  64'(8'hDD));
        chk("wr_grant",  64'(a_grant), 64'(2'b10));
        tick;
        chk("wr_wr2",    64'(a_wr),    64'(1));
        chk("wr_addr2",  64'(a_addr),  64'(32'h21));
        chk("wr_dout2",  64'(a_dout),  64'(8'hCC));
        tick;
        chk("wr_ack",    64'(a_ack),   64'(2'b10));
        chk("wr_wr_off", 64'(a_wr),    64'(0));
        a_req = 2'b00; a_we = 2'b00;
        tick;
        chk("wr_mem20", 64'(mem_a[10'h020]), 64'(8'hDD));
        chk("wr_mem21", 64'(mem_a[10'h021]), 64'(8'hCC));
        chk("wr_mem22", 64'(mem_a[10'h022]), 64'(8'h5A));
        chk("wr_mem23", 64'(mem_a[10'h023]), 64'(8'hA5));

        // fixed priority: ch1 beats ch0
        a_req = 2'b11; a_len = {3'd1, 3'd1}; a_addr_i = {32'h101, 32'h100};
        tick;
        chk("fp_grant1", 64'(a_grant), 64'(2'b10));
        tick; tick;
        chk("fp_ack1",   64'(a_ack),   64'(2'b10));
        chk("fp_rdata1", 64'(a_rdata), 64'(32'h22));
        a_req = 2'b01;
        tick;
        chk("fp_idle",   64'(a_busy),  64'(0));
        tick;
        chk("fp_grant0", 64'(a_grant), 64'(2'b01));
        tick; tick;
        chk("fp_ack0",   64'(a_ack),   64'(2'b01));
        chk("fp_rdata0", 64'(a_rdata), 64'(32'h11));
        a_req = 2'b00;
        tick;

        // flush active read on ch0, ch1 write waiting
        a_req = 2'b01; a_len[2:0] = 3'd4; a_addr_i[31:0] = 32'h102;
        tick;
        chk("fl_grant0", 64'(a_grant), 64'(2'b01));
        a_req = 2'b11; a_we = 2'b10; a_len[5:3] = 3'd1; a_addr_i[63:32] = 32'h30;
        a_wdata[63:32] = 32'h77;
        tick;
        a_flush = 2'b01;
        tick;
        chk("fl_busy",  64'(a_busy),  64'(0));
        chk("fl_ack",   64'(a_ack),   64'(0));
        chk("fl_rdata", 64'(a_rdata), 64'(32'h11));
        a_flush = 2'b00; a_req = 2'b10;
        tick;
        chk("fl_grant1", 64'(a_grant), 64'(2'b10));
        chk("fl_wr",     64'(a_wr),    64'(1));
        chk("fl_addr",   64'(a_addr),  64'(32'h30));
        chk("fl_dout",   64'(a_dout),  64'(8'h77));
        tick;
        chk("fl_ack1",   64'(a_ack),   64'(2'b10));
        a_req = 2'b00; a_we = 2'b00;
        tick;

        // len=7 write clamps to 4 bytes
        a_req = 2'b01; a_we = 2'b01; a_len[2:0] = 3'd7; a_addr_i[31:0] = 32'h60;
        a_wdata[31:0] = 32'h0D0C0B0A;
        for (int i = 0; i < 4; i++) begin
            tick;
            chk("cl_wr",   64'(a_wr),   64'(1));
            chk("cl_addr", 64'(a_addr), 64'(32'h60 + i));
            chk("cl_dout", 64'(a_dout), 64'(8'h0A + i));
        end
        tick;
        chk("cl_ack", 64'(a_ack), 64'(2'b01));
        a_req = 2'b00; a_we = 2'b00;
        tick;

        // reset in the middle of a write
        a_req = 2'b10; a_we = 2'b10; a_len[5:3] = 3'd4; a_addr_i[63:32] = 32'h40;
        a_wdata[63:32] = 32'h01020304;
        tick;
        chk("rs_wr_pre", 64'(a_wr), 64'(1));
        rst = 1'b1;
        tick;
        chk("rs_busy",  64'(a_busy),  64'(0));
        chk("rs_grant", 64'(a_grant), 64'(0));
        chk("rs_ack",   64'(a_ack),   64'(0));
        chk("rs_wr",    64'(a_wr),    64'(0));
        chk("rs_addr",  64'(a_addr),  64'(0));
        chk("rs_dout",  64'(a_dout),  64'(0));
        chk("rs_rdata", 64'(a_rdata), 64'(0));
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick;
            chk("rs2_addr", 64'(a_addr), 64'(32'h40 + i));
            chk("rs2_dout", 64'(a_dout), 64'(8'h04 - i));
        end
        tick;
        chk("rs2_ack", 64'(a_ack), 64'(2'b10));
        a_req = 2'b00; a_we = 2'b00;
        tick;
        chk("rs2_mem40", 64'(mem_a[10'h040]), 64'(8'h04));
        chk("rs2_mem43", 64'(mem_a[10'h043]), 64'(8'h01));

        // round robin, both channels held
        b_req = 2'b11; b_len = {3'd1, 3'd1}; b_addr_i = {32'h11, 32'h10};
        for (int k = 0; k < 4; k++) begin
            eg = (k % 2 == 0) ? 2'b01 : 2'b10;
            tick;
            chk("rr_grant", 64'(b_grant), 64'(eg));
            tick; tick; tick;
            chk("rr_ack",   64'(b_ack),   64'(eg));
            chk("rr_rdata", 64'(b_rdata), (k % 2 == 0) ? 64'(8'hA0) : 64'(8'hB1));
            tick;
            chk("rr_idle",  64'(b_busy),  64'(0));
        end
        b_req = 2'b00;

        // rdy pause during a write
        b_req = 2'b10; b_we = 2'b10; b_len[5:3] = 3'd1; b_addr_i[63:32] = 32'h50;
        b_wdata[63:32] = 32'h99;
        tick;
        chk("pw_wr_on", 64'(b_wr), 64'(1));
        rdy = 1'b0;
        #1;
        chk("pw_wr_off", 64'(b_wr),   64'(0));
        chk("pw_addr",   64'(b_addr), 64'(32'h50));
        chk("pw_dout",   64'(b_dout), 64'(8'h99));
        tick;
        chk("pw_busy",   64'(b_busy), 64'(1));
        chk("pw_no_ack", 64'(b_ack),  64'(0));
        rdy = 1'b1;
        #1;
        chk("pw_wr_res", 64'(b_wr),   64'(1));
        tick;
        chk("pw_ack",    64'(b_ack),  64'(2'b10));
        b_req = 2'b00; b_we = 2'b00;
        tick;
        chk("pw_mem50", 64'(mem_b[10'h050]), 64'(8'h99));

        // rdy pause for 3 cycles during a read, RD_LAT=2
        b_req = 2'b01; b_len[2:0] = 3'd1; b_addr_i[31:0] = 32'hFFFFFFFF;
        tick;
        chk("pr_addr1", 64'(b_addr), 64'(32'hFFFFFFFF));
        tick;
        rdy = 1'b0;
        #1;
        chk("pr_wr",    64'(b_wr),   64'(0));
        chk("pr_addr2", 64'(b_addr), 64'(32'hFFFFFFFF));
        tick;
        chk("pr_addr3", 64'(b_addr), 64'(32'hFFFFFFFF));
        chk("pr_ack3",  64'(b_ack),  64'(0));
        tick;
        chk("pr_ack4",  64'(b_ack),  64'(0));
        tick;
        rdy = 1'b1;
        tick;
        chk("pr_ack6",  64'(b_ack),  64'(0));
        chk("pr_busy6", 64'(b_busy), 64'(1));
        tick;
        chk("pr_ack",   64'(b_ack),   64'(2'b01));
        chk("pr_rdata", 64'(b_rdata), 64'(32'h0000007E));
        b_req = 2'b00;
        tick;

        // address wrap at the top of memory
        b_req = 2'b01; b_len[2:0] = 3'd2; b_addr_i[31:0] = 32'hFFFFFFFF;
        tick;
        chk("wp_addr1", 64'(b_addr), 64'(32'hFFFFFFFF));
        tick;
        chk("wp_addr2", 64'(b_addr), 64'(32'h00000000));
        tick; tick; tick;
        chk("wp_ack",   64'(b_ack),   64'(2'b01));
        chk("wp_rdata", 64'(b_rdata), 64'(32'h00005C7E));
        b_req = 2'b00;
        tick;

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Parametrised successor to the two-client byte-serial RAM controller.
- Arbitrates NUM_CH requesters (instruction fetch, load/store, future cache refill) onto the single 8-bit RAM port of the CPU core.
- Converts 1..4-byte word requests into little-endian byte sequences, with configurable RAM read latency, fixed-priority or round-robin arbitration, and per-channel read abort (flush).

Parameters:
NUM_CH, 2, number of requesting channels (1..8)
ADDR_W, 32, address width
DATA_W, 32, request data width (multiple of 8, max 32)
RD_LAT, 1, cycles from addr_o to valid din (1..3)
ARB_MODE, 0, 0 = fixed priority (highest index wins), 1 = round robin

Ports:
clk  in  1  clock
rst  in  1  reset; synchronous, active-high
rdy  in  1  global pause; 0 freezes the block
req_i  in  NUM_CH  request per channel
we_i  in  NUM_CH  1 = write, 0 = read
len_i  in  3*NUM_CH  byte count per channel
addr_i  in  ADDR_W*NUM_CH  base byte address per channel
wdata_i  in  DATA_W*NUM_CH  write data per channel, byte 0 at addr
flush_i  in  NUM_CH  cancel channel's pending or active read
ack_o  out  NUM_CH  one-cycle completion pulse
rdata_o  out  DATA_W  read data, valid while ack_o != 0
grant_o  out  NUM_CH  one-hot active channel
busy_o  out  1  transfer in progress
din  in  8  RAM read byte
dout  out  8  RAM write byte
addr_o  out  ADDR_W  RAM byte address
wr_o  out  1  RAM write strobe

Behaviour:
- Reset: state IDLE; ack_o = 0, rdata_o = 0, grant_o = 0, busy_o = 0, addr_o = 0, dout = 0, wr_o = 0; round-robin pointer = NUM_CH-1, so ch0 wins first.
- States: IDLE, XFER, DONE.
- IDLE:
  - Eligible channels are those with req_i=1 and flush_i=0.
  - If any channel is eligible and rdy=1, the arbiter picks the winner and latches its addr, len, we and wdata at the edge, then enters XFER with cnt=0.
  - Fixed mode: highest index wins. RR mode: search starts at pointer+1 and wraps; the pointer updates to the winner on grant.
- Length rules: len 0 is treated as 1; len > DATA_W/8 clamps to DATA_W/8.
- XFER, write: per cycle cnt drives addr_o = base+cnt, dout = wdata byte cnt, wr_o = 1. Duration is len cycles, then DONE.
- XFER, read:
  - Issues addr_o = base+cnt for cnt < len; addr_o is held at the last address afterwards; wr_o = 0.
  - At cnt >= RD_LAT, captures din into rdata byte (cnt-RD_LAT).
  - Duration is len+RD_LAT cycles, then DONE.
  - Uncaptured upper bytes read as 0 (zero-extension; sign extension belongs to MEM).
- Address arithmetic: base+cnt is computed modulo 2^ADDR_W, wrapping at the top of memory.
- DONE: lasts one cycle. ack_o[ch] = 1, rdata_o valid, grant_o/busy_o still asserted. Next state is IDLE, and no grant is made in DONE.
- Outside XFER: addr_o = 0, dout = 0, wr_o = 0.
- Latency: request seen in IDLE at cycle 0 → 4-byte read, RD_LAT=1: XFER cycles 1-5, ack at cycle 6. 4-byte write: ack at cycle 5.
- grant_o and busy_o are asserted during XFER and DONE only.
- rdy=0:
  - FSM, cnt and captures freeze; wr_o is forced 0; addr_o and dout hold.
  - The RAM is paused by the same rdy, so din holds.
  - ack_o pulses only in cycles with rdy=1.
- flush_i on the active read channel: the transfer ends at that edge, state goes to IDLE, no ack, rdata_o is unchanged.
- flush_i on an active write is ignored, so writes always complete.
- flush_i on a non-active channel only masks it from arbitration that cycle.
- Requesters hold req_i and operands until ack or flush. A req_i drop mid-transfer is ignored; the block works on latched values.
- Simultaneous ack and new request from the same channel: the request is considered in the following IDLE cycle.
- rst asserted mid-transfer: abort immediately to reset values; no ack.

Test Plan:
- Reset, then ch0 reads len=4 at 0x100, RAM bytes 11,22,33,44, RD_LAT=1 → addr_o 0x100..0x103 on cycles 1-4, ack_o=01 at cycle 6, rdata_o=0x44332211.
- ch1 writes len=2, wdata 0xAABBCCDD at 0x20 → wr_o=1 with (0x20,DD) then (0x21,CC), ack_o=10 at cycle 3, RAM bytes 0x22/0x23 untouched.
- ARB_MODE=0, ch0 and ch1 request together → ch1 granted first; ch0 acked after ch1's DONE plus one IDLE cycle. ARB_MODE=1, both held continuously → grants alternate 0,1,0,1.
- ch0 read len=4, flush_i[0] pulsed in the 2nd XFER cycle → busy_o low the next cycle, no ack_o, ch1 granted in the following IDLE.
- rdy held low for 3 cycles mid-read (RD_LAT=2, len=1, 0xFFFFFFFF, RAM byte 7E) → wr_o=0, addr_o stable during the pause, ack delayed exactly 3 cycles, rdata_o=0x0000007E; address wrap is verified with len=2 reading 0xFFFFFFFF then 0x00000000.
- rst pulsed during a write XFER → all outputs 0 next cycle, no ack; a subsequent request completes normally.
